// File: rtl/burst_rom_if.sv
// burst_rom_if: request/response handshake bundle for burst_rom.
//   Request  : req_valid, req_ready, req_addr (start address), req_len (beats - 1)
//   Response : rsp_valid, rsp_ready, rsp_data, rsp_err (address out of range),
//              rsp_last (final beat of the burst)
//   Status   : busy (a burst is in progress)
// Modports: slave = the ROM side, master = the requester/consumer side.
interface burst_rom_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              rsp_last;
  logic              busy;

  modport slave (
    input  req_valid, req_addr, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_last, busy
  );

  modport master (
    output req_valid, req_addr, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_last, busy
  );
endinterface

// File: rtl/burst_rom.sv
// burst_rom: fixed-content ROM read in bursts of consecutive addresses.
//   Word i holds (i * STRIDE) mod 2^DATA_W for i < DEPTH; addresses at or
//   above DEPTH return OOB_DATA with rsp_err set. A request (start address,
//   length-1) is accepted in IDLE; beats follow one per cycle while the
//   consumer is ready, address wrapping modulo 2^ADDR_W.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - burst_rom_if.slave (request, response, busy)
module burst_rom #(
  parameter int                ADDR_W   = 4,
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 10,
  parameter int                LEN_W    = 4,
  parameter logic [DATA_W-1:0] STRIDE   = 8'h11,
  parameter logic [DATA_W-1:0] OOB_DATA = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  burst_rom_if.slave bus
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [LEN_W-1:0]  cnt_q,   cnt_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              err_q,   err_d;
  logic              last_q,  last_d;
  logic [ADDR_W-1:0] addr_nxt;

  function automatic logic is_oob(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= (ADDR_W+1)'(DEPTH);
  endfunction

  // Content is a pure function of the address, so the "ROM" is just this
  // constant-coefficient product.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] idx;
    idx = DATA_W'(a);
    if (is_oob(a)) return OOB_DATA;
    return idx * STRIDE;
  endfunction

  // cnt_q counts beats remaining after the one currently presented; the
  // response word/err/last for the next beat are computed one cycle ahead
  // so every output comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    err_d    = err_q;
    last_d   = last_q;
    addr_nxt = addr_q + ADDR_W'(1);
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = BURST;
          addr_d  = bus.req_addr;
          cnt_d   = bus.req_len;
          data_d  = rom_word(bus.req_addr);
          err_d   = is_oob(bus.req_addr);
          last_d  = (bus.req_len == '0);
        end
      end
      BURST: begin
        // req_valid is deliberately not looked at here.
        if (bus.rsp_ready) begin
          if (last_q) begin
            state_d = IDLE;
            addr_d  = '0;
            cnt_d   = '0;
            data_d  = '0;
            err_d   = 1'b0;
            last_d  = 1'b0;
          end else begin
            addr_d  = addr_nxt;
            cnt_d   = cnt_q - LEN_W'(1);
            data_d  = rom_word(addr_nxt);
            err_d   = is_oob(addr_nxt);
            last_d  = (cnt_q == LEN_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == BURST);
  assign bus.rsp_valid = (state_q == BURST);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_last  = last_q;

endmodule

// File: doc/burst_rom.md
BURST_ROM -- requirements
Module: burst_rom

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8: data word width in bits.
REQ-003 SHALL have parameter DEPTH, default 10: number of valid words, 1 <= DEPTH <= 2^ADDR_W.
REQ-004 SHALL have parameter LEN_W, default 4: burst-length field width in bits.
REQ-005 SHALL have parameter STRIDE, default 8'h11 (DATA_W bits): content generator.
REQ-006 SHALL have parameter OOB_DATA, default 0 (DATA_W bits): data returned for out-of-range addresses.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port req_valid, input, 1 bit: a burst request is present.
REQ-010 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-011 SHALL have port req_addr, input, ADDR_W bits: start address.
REQ-012 SHALL have port req_len, input, LEN_W bits: beat count minus 1.
REQ-013 SHALL have port rsp_valid, output, 1 bit: a response beat is present.
REQ-014 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the beat.
REQ-015 SHALL have port rsp_data, output, DATA_W bits: the word read.
REQ-016 SHALL have port rsp_err, output, 1 bit: the beat address is >= DEPTH.
REQ-017 SHALL have port rsp_last, output, 1 bit: the final beat of the burst.
REQ-018 SHALL have port busy, output, 1 bit: a burst is in progress.

Function
REQ-019 SHALL hold content word i = (i * STRIDE) mod 2^DATA_W for 0 <= i < DEPTH; content is fixed at elaboration.
REQ-020 SHALL implement an FSM with two states: IDLE (req_ready=1, busy=0, rsp_valid=0) and BURST (req_ready=0, busy=1, rsp_valid=1).
REQ-021 SHALL accept a request when req_valid && req_ready, latch req_addr and req_len, and enter BURST.
REQ-022 SHALL present the first beat with rsp_valid=1 on the cycle after acceptance (1-cycle latency, registered outputs).
REQ-023 SHALL issue exactly req_len+1 beats at consecutive addresses; a beat completes when rsp_valid && rsp_ready.
REQ-024 SHALL hold rsp_data, rsp_err and rsp_last stable while rsp_valid=1 and rsp_ready=0.
REQ-025 SHALL present the next beat on the cycle after a beat completes, giving 1 beat/cycle under continuous rsp_ready.
REQ-026 SHALL wrap the beat address modulo 2^ADDR_W (2^ADDR_W-1 -> 0), not saturate.
REQ-027 SHALL, for beat address >= DEPTH, drive rsp_data=OOB_DATA and rsp_err=1; otherwise rsp_err=0; the burst continues either way.
REQ-028 SHALL drive rsp_last=1 only on the final beat.
REQ-029 SHALL return to IDLE on completion of the last beat, so req_ready=1 on the next cycle; there is no same-cycle back-to-back acceptance.
REQ-030 SHALL ignore req_valid while in BURST, with no latch and no effect on the burst in progress.
REQ-031 SHALL treat req_len=0 as a single beat with rsp_last=1.

Reset
REQ-032 SHALL, while rst_n=0, force IDLE immediately, without waiting for a clock edge: req_ready=1, busy=0, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_last=0, internal address and counter 0.
REQ-033 SHALL, on reset mid-burst, abandon remaining beats without emitting them; the first request after rst_n rises is accepted normally.

Verification (defaults: DEPTH=10, STRIDE=0x11, rsp_ready=1 unless stated)
REQ-034 SHALL cover a single read: addr=3, len=0 -> one beat 0x33, err=0, last=1, rsp_valid exactly 1 cycle after accept.
REQ-035 SHALL cover a burst crossing DEPTH: addr=8, len=2 -> 0x88/err0, 0x99/err0, 0x00/err1/last=1, on consecutive cycles.
REQ-036 SHALL cover wrap-around: addr=15, len=1 -> OOB_DATA/err1, then 0x00/err0/last=1.
REQ-037 SHALL cover backpressure: addr=1, len=1, rsp_ready=0 for 3 cycles -> 0x11 held stable with rsp_valid=1 for 3 cycles, then 0x11, 0x22/last on ready.
REQ-038 SHALL cover a request during a burst: req_valid=1, addr=5 asserted in BURST -> ignored; after return to IDLE the same request yields 0x55.
REQ-039 SHALL cover reset mid-burst: addr=0, len=7, rst_n low after beat 2 -> outputs immediately reach reset values; a new request addr=2, len=0 then returns 0x22/last=1.
